// File: rtl/pipe_pkg.sv
// Shared encodings for the ID/EX pipeline register and its ALU interface.
//   CS_*   : 3-bit control-signal class presented on the ALU cs input
//   F7_*   : funct7 encodings the ALU decodes specially
//   fwd_sel_e : which source an operand forwarding mux selected
package pipe_pkg;

    localparam logic [2:0] CS_LOAD   = 3'b000;
    localparam logic [2:0] CS_ITYPE  = 3'b001;
    localparam logic [2:0] CS_STORE  = 3'b010;
    localparam logic [2:0] CS_RTYPE  = 3'b011;
    localparam logic [2:0] CS_BRANCH = 3'b110;
    localparam logic [2:0] CS_NOP    = 3'b111;

    localparam logic [6:0] F7_SUB = 7'b0100000;
    localparam logic [6:0] F7_MUL = 7'b0000001;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/forward_mux.sv
// Operand bypass selector for one source register.
//   rs_idx / reg_data        : registered source index and register-file value
//   exmem_* / memwb_*        : destination, write-enable and value of the two
//                              younger in-flight producers
//   value                    : resolved operand
//   sel                      : which source was chosen
// x0 is never forwarded; the nearer (EX/MEM) producer wins over MEM/WB.
module forward_mux
    import pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      rs_idx,
    input  logic [XLEN-1:0] reg_data,
    input  logic [4:0]      exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [4:0]      memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_result,
    output logic [XLEN-1:0] value,
    output fwd_sel_e        sel
);

    always_comb begin
        sel = FWD_REG;
        if (rs_idx != 5'd0) begin
            if (exmem_reg_write && (exmem_rd == rs_idx)) begin
                sel = FWD_EXMEM;
            end else if (memwb_reg_write && (memwb_rd == rs_idx)) begin
                sel = FWD_MEMWB;
            end
        end
    end

    always_comb begin
        case (sel)
            FWD_EXMEM: value = exmem_result;
            FWD_MEMWB: value = memwb_result;
            default:   value = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU.
//   Inputs : clk, rst_n (async, active low), flush, ex_hold, decode bundle
//            id_*, and the EX/MEM and MEM/WB bypass ports.
//   Outputs: id_ready handshake, ALU drive (ex_cs, ex_funct7, ex_funct3,
//            ex_x1, ex_x2), ex_store_data, ex_rd, ex_reg_write, ex_valid and
//            a saturating load-use bubble counter stall_count.
// Per-edge priority: flush > hold > load-use bubble > accept > bubble.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             ex_hold,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [2:0]       id_cs,
    input  logic [6:0]       id_funct7,
    input  logic [2:0]       id_funct3,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_use_imm,
    input  logic             id_reg_write,
    input  logic [4:0]       exmem_rd,
    input  logic             exmem_reg_write,
    input  logic [XLEN-1:0]  exmem_result,
    input  logic [4:0]       memwb_rd,
    input  logic             memwb_reg_write,
    input  logic [XLEN-1:0]  memwb_result,
    output logic             ex_valid,
    output logic [2:0]       ex_cs,
    output logic [6:0]       ex_funct7,
    output logic [2:0]       ex_funct3,
    output logic [XLEN-1:0]  ex_x1,
    output logic [XLEN-1:0]  ex_x2,
    output logic [XLEN-1:0]  ex_store_data,
    output logic [4:0]       ex_rd,
    output logic             ex_reg_write,
    output logic [CNT_W-1:0] stall_count
);

    logic             valid_q,     valid_d;
    logic [2:0]       cs_q,        cs_d;
    logic [6:0]       funct7_q,    funct7_d;
    logic [2:0]       funct3_q,    funct3_d;
    logic [4:0]       rs1_q,       rs1_d;
    logic [4:0]       rs2_q,       rs2_d;
    logic [4:0]       rd_q,        rd_d;
    logic [XLEN-1:0]  rs1_data_q,  rs1_data_d;
    logic [XLEN-1:0]  rs2_data_q,  rs2_data_d;
    logic [XLEN-1:0]  imm_q,       imm_d;
    logic             use_imm_q,   use_imm_d;
    logic             reg_write_q, reg_write_d;
    logic [CNT_W-1:0] stall_q,     stall_d;

    logic [XLEN-1:0]  fwd_rs1, fwd_rs2;
    fwd_sel_e         sel_rs1, sel_rs2;
    logic             load_use;

    forward_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs_idx          (rs1_q),
        .reg_data        (rs1_data_q),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .value           (fwd_rs1),
        .sel             (sel_rs1)
    );

    forward_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs_idx          (rs2_q),
        .reg_data        (rs2_data_q),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .value           (fwd_rs2),
        .sel             (sel_rs2)
    );

    // rs2 only matters for the hazard when it is actually read: R-type
    // operand or store data. I-type/load rs2 fields are immediate bits.
    always_comb begin
        load_use = valid_q && (cs_q == CS_LOAD) && (rd_q != 5'd0) && id_valid &&
                   ((id_rs1 == rd_q) ||
                    ((id_rs2 == rd_q) && (!id_use_imm || (id_cs == CS_STORE))));
    end

    assign id_ready = !ex_hold && !load_use;

    always_comb begin
        valid_d     = valid_q;
        cs_d        = cs_q;
        funct7_d    = funct7_q;
        funct3_d    = funct3_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        use_imm_d   = use_imm_q;
        reg_write_d = reg_write_q;
        stall_d     = stall_q;

        if (flush) begin
            valid_d     = 1'b0;
            cs_d        = CS_NOP;
            reg_write_d = 1'b0;
        end else if (ex_hold) begin
            // Absorb any bypassed value now: the producer may retire from
            // EX/MEM or MEM/WB before the hold releases.
            if (sel_rs1 != FWD_REG) rs1_data_d = fwd_rs1;
            if (sel_rs2 != FWD_REG) rs2_data_d = fwd_rs2;
        end else if (load_use) begin
            valid_d     = 1'b0;
            cs_d        = CS_NOP;
            reg_write_d = 1'b0;
            if (stall_q != {CNT_W{1'b1}}) stall_d = stall_q + 1'b1;
        end else if (id_valid) begin
            valid_d     = 1'b1;
            cs_d        = id_cs;
            funct7_d    = id_funct7;
            funct3_d    = id_funct3;
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            rd_d        = id_rd;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
            imm_d       = id_imm;
            use_imm_d   = id_use_imm;
            reg_write_d = id_reg_write;
        end else begin
            valid_d     = 1'b0;
            cs_d        = CS_NOP;
            reg_write_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            cs_q        <= CS_NOP;
            funct7_q    <= '0;
            funct3_q    <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            reg_write_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            valid_q     <= valid_d;
            cs_q        <= cs_d;
            funct7_q    <= funct7_d;
            funct3_q    <= funct3_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            reg_write_q <= reg_write_d;
            stall_q     <= stall_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_cs         = valid_q ? cs_q : CS_NOP;
    assign ex_funct7     = funct7_q;
    assign ex_funct3     = funct3_q;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = valid_q && reg_write_q;
    assign ex_x1         = fwd_rs1;
    assign ex_x2         = use_imm_q ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign stall_count   = stall_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush, ex_hold, id_valid, id_ready;
    logic [2:0]       id_cs, id_funct3;
    logic [6:0]       id_funct7;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0]  id_rs1_data, id_rs2_data, id_imm;
    logic             id_use_imm, id_reg_write;
    logic [4:0]       exmem_rd, memwb_rd;
    logic             exmem_reg_write, memwb_reg_write;
    logic [XLEN-1:0]  exmem_result, memwb_result;
    logic             ex_valid, ex_reg_write;
    logic [2:0]       ex_cs, ex_funct3;
    logic [6:0]       ex_funct7;
    logic [XLEN-1:0]  ex_x1, ex_x2, ex_store_data;
    logic [4:0]       ex_rd;
    logic [CNT_W-1:0] stall_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .ex_hold(ex_hold),
        .id_valid(id_valid), .id_ready(id_ready), .id_cs(id_cs),
        .id_funct7(id_funct7), .id_funct3(id_funct3), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_use_imm(id_use_imm),
        .id_reg_write(id_reg_write), .exmem_rd(exmem_rd),
        .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
        .memwb_result(memwb_result), .ex_valid(ex_valid), .ex_cs(ex_cs),
        .ex_funct7(ex_funct7), .ex_funct3(ex_funct3), .ex_x1(ex_x1),
        .ex_x2(ex_x2), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .stall_count(stall_count)
    );

    // Stimulus drivers only; every comparison lives in the test tasks.
    task automatic idle_inputs();
        flush = 0; ex_hold = 0; id_valid = 0; id_cs = 3'b111;
        id_funct7 = 0; id_funct3 = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_use_imm = 0;
        id_reg_write = 0; exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
        memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
    endtask

    task automatic offer(input logic [2:0] cs, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic use_imm);
        id_valid = 1; id_cs = cs; id_funct7 = 7'b0000000; id_funct3 = 3'b000;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rs1_data = d1;
        id_rs2_data = d2; id_imm = imm; id_use_imm = use_imm;
        id_reg_write = (cs != 3'b010);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        if (ex_valid !== 1'b0) begin $display("FAIL reset_valid got=%0d want=0", ex_valid); errors++; end
        checks++;
        if (ex_cs !== 3'b111) begin $display("FAIL reset_cs got=%b want=111", ex_cs); errors++; end
        checks++;
        if (ex_x1 !== 32'd0 || ex_x2 !== 32'd0 || ex_store_data !== 32'd0) begin
            $display("FAIL reset_operands got x1=%0d x2=%0d sd=%0d want=0", ex_x1, ex_x2, ex_store_data); errors++;
        end
        checks++;
        if (stall_count !== 16'd0 || ex_reg_write !== 1'b0) begin
            $display("FAIL reset_misc got stall=%0d rw=%0d want=0", stall_count, ex_reg_write); errors++;
        end
        checks++;
        rst_n = 1;
        $display("txn reset: outputs cleared");
    endtask

    task automatic test_rtype();
        @(negedge clk);
        offer(3'b011, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 32'd0, 1'b0);
        #1;
        if (id_ready !== 1'b1) begin $display("FAIL rtype_ready got=%0d want=1", id_ready); errors++; end
        checks++;
        @(posedge clk); #1;
        if (ex_x1 !== 32'd5 || ex_x2 !== 32'd7) begin
            $display("FAIL rtype_operands got x1=%0d x2=%0d want x1=5 x2=7", ex_x1, ex_x2); errors++;
        end
        checks++;
        if (ex_cs !== 3'b011 || ex_valid !== 1'b1 || ex_rd !== 5'd5 || ex_reg_write !== 1'b1) begin
            $display("FAIL rtype_ctrl got cs=%b v=%0d rd=%0d rw=%0d want cs=011 v=1 rd=5 rw=1",
                     ex_cs, ex_valid, ex_rd, ex_reg_write); errors++;
        end
        checks++;
        $display("txn rtype: x1=%0d x2=%0d cs=%b", ex_x1, ex_x2, ex_cs);
    endtask

    task automatic test_forward();
        @(negedge clk);
        offer(3'b001, 5'd3, 5'd3, 5'd9, 32'd55, 32'd66, 32'd12, 1'b1);
        exmem_rd = 5'd3; exmem_reg_write = 1; exmem_result = 32'd100;
        memwb_rd = 5'd3; memwb_reg_write = 1; memwb_result = 32'd200;
        @(posedge clk); #1;
        id_valid = 0;
        if (ex_x1 !== 32'd100) begin $display("FAIL fwd_exmem got=%0d want=100", ex_x1); errors++; end
        checks++;
        if (ex_x2 !== 32'd12 || ex_store_data !== 32'd100) begin
            $display("FAIL fwd_imm got x2=%0d sd=%0d want x2=12 sd=100", ex_x2, ex_store_data); errors++;
        end
        checks++;
        exmem_reg_write = 0; #1;
        if (ex_x1 !== 32'd200) begin $display("FAIL fwd_memwb got=%0d want=200", ex_x1); errors++; end
        checks++;
        memwb_reg_write = 0; #1;
        if (ex_x1 !== 32'd55) begin $display("FAIL fwd_none got=%0d want=55", ex_x1); errors++; end
        checks++;
        // x0 source must never pick up a bypass that also names x0.
        @(negedge clk);
        offer(3'b011, 5'd0, 5'd0, 5'd9, 32'd77, 32'd88, 32'd0, 1'b0);
        exmem_rd = 5'd0; exmem_reg_write = 1; exmem_result = 32'd100;
        memwb_rd = 5'd0; memwb_reg_write = 1; memwb_result = 32'd200;
        @(posedge clk); #1;
        id_valid = 0;
        if (ex_x1 !== 32'd77 || ex_x2 !== 32'd88) begin
            $display("FAIL fwd_x0 got x1=%0d x2=%0d want x1=77 x2=88", ex_x1, ex_x2); errors++;
        end
        checks++;
        exmem_reg_write = 0; memwb_reg_write = 0;
        $display("txn forward: exmem/memwb/x0 priority");
    endtask

    task automatic test_load_use();
        @(negedge clk);
        offer(3'b000, 5'd1, 5'd0, 5'd4, 32'd1000, 32'd0, 32'd8, 1'b1);
        @(negedge clk);
        offer(3'b011, 5'd2, 5'd4, 5'd8, 32'd1, 32'd2, 32'd0, 1'b0);
        #1;
        if (id_ready !== 1'b0) begin $display("FAIL lu_ready got=%0d want=0", id_ready); errors++; end
        checks++;
        @(posedge clk); #1;
        if (ex_valid !== 1'b0 || ex_cs !== 3'b111 || ex_reg_write !== 1'b0) begin
            $display("FAIL lu_bubble got v=%0d cs=%b rw=%0d want v=0 cs=111 rw=0", ex_valid, ex_cs, ex_reg_write); errors++;
        end
        checks++;
        if (stall_count !== 16'd1) begin $display("FAIL lu_count got=%0d want=1", stall_count); errors++; end
        checks++;
        @(posedge clk); #1;
        if (ex_valid !== 1'b1 || ex_cs !== 3'b011 || ex_rd !== 5'd8) begin
            $display("FAIL lu_accept got v=%0d cs=%b rd=%0d want v=1 cs=011 rd=8", ex_valid, ex_cs, ex_rd); errors++;
        end
        checks++;
        id_valid = 0;
        $display("txn load_use: bubble then accept, stall_count=%0d", stall_count);
    endtask

    task automatic test_imm_no_stall();
        @(negedge clk);
        offer(3'b000, 5'd1, 5'd0, 5'd4, 32'd1000, 32'd0, 32'd8, 1'b1);
        @(negedge clk);
        offer(3'b001, 5'd2, 5'd4, 5'd9, 32'd3, 32'd0, 32'd4, 1'b1);
        #1;
        if (id_ready !== 1'b1) begin $display("FAIL imm_ready got=%0d want=1", id_ready); errors++; end
        checks++;
        @(posedge clk); #1;
        if (ex_valid !== 1'b1 || ex_cs !== 3'b001 || stall_count !== 16'd1) begin
            $display("FAIL imm_accept got v=%0d cs=%b stall=%0d want v=1 cs=001 stall=1", ex_valid, ex_cs, stall_count); errors++;
        end
        checks++;
        @(negedge clk);
        offer(3'b000, 5'd1, 5'd0, 5'd4, 32'd1000, 32'd0, 32'd8, 1'b1);
        @(negedge clk);
        offer(3'b010, 5'd2, 5'd4, 5'd0, 32'd3, 32'd9, 32'd16, 1'b1);
        #1;
        if (id_ready !== 1'b0) begin $display("FAIL store_ready got=%0d want=0", id_ready); errors++; end
        checks++;
        @(posedge clk); #1;
        if (ex_valid !== 1'b0 || stall_count !== 16'd2) begin
            $display("FAIL store_bubble got v=%0d stall=%0d want v=0 stall=2", ex_valid, stall_count); errors++;
        end
        checks++;
        @(posedge clk); #1;
        id_valid = 0;
        $display("txn imm/store hazard: stall_count=%0d", stall_count);
    endtask

    task automatic test_hold();
        @(negedge clk);
        offer(3'b011, 5'd6, 5'd0, 5'd7, 32'd0, 32'd0, 32'd0, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        ex_hold = 1;
        offer(3'b011, 5'd11, 5'd12, 5'd13, 32'd1, 32'd1, 32'd0, 1'b0);
        memwb_rd = 5'd6; memwb_reg_write = 1; memwb_result = 32'd42;
        #1;
        if (ex_x1 !== 32'd42 || id_ready !== 1'b0) begin
            $display("FAIL hold_c1 got x1=%0d ready=%0d want x1=42 ready=0", ex_x1, id_ready); errors++;
        end
        checks++;
        @(negedge clk);
        memwb_reg_write = 0; memwb_result = 32'd999;
        #1;
        if (ex_x1 !== 32'd42) begin $display("FAIL hold_c2 got=%0d want=42", ex_x1); errors++; end
        checks++;
        @(negedge clk);
        if (ex_x1 !== 32'd42 || ex_valid !== 1'b1 || ex_rd !== 5'd7) begin
            $display("FAIL hold_c3 got x1=%0d v=%0d rd=%0d want x1=42 v=1 rd=7", ex_x1, ex_valid, ex_rd); errors++;
        end
        checks++;
        $display("txn hold: x1=%0d held", ex_x1);
    endtask

    task automatic test_flush_hold();
        // ex_hold is still high from test_hold with a live instruction.
        @(negedge clk);
        flush = 1;
        @(posedge clk); #1;
        if (ex_valid !== 1'b0 || ex_cs !== 3'b111 || ex_reg_write !== 1'b0) begin
            $display("FAIL flush_hold got v=%0d cs=%b rw=%0d want v=0 cs=111 rw=0", ex_valid, ex_cs, ex_reg_write); errors++;
        end
        checks++;
        ex_hold = 0; #1;
        if (id_ready !== 1'b1) begin $display("FAIL flush_ready got=%0d want=1", id_ready); errors++; end
        checks++;
        @(negedge clk);
        flush = 0; id_valid = 0;
        $display("txn flush+hold: stage emptied");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        offer(3'b011, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 32'd0, 1'b0);
        @(posedge clk); #1;
        ex_hold = 1;
        @(negedge clk); #2;
        rst_n = 0; #1;
        if (ex_valid !== 1'b0 || ex_cs !== 3'b111 || ex_x1 !== 32'd0 || ex_x2 !== 32'd0 ||
            ex_rd !== 5'd0 || stall_count !== 16'd0) begin
            $display("FAIL async_reset got v=%0d cs=%b x1=%0d x2=%0d rd=%0d stall=%0d want 0/111/0/0/0/0",
                     ex_valid, ex_cs, ex_x1, ex_x2, ex_rd, stall_count); errors++;
        end
        checks++;
        @(negedge clk);
        rst_n = 1; idle_inputs();
        $display("txn async reset mid-hold: outputs cleared");
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_forward();
        test_load_use();
        test_imm_no_stall();
        test_hold();
        test_flush_hold();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
